// File: rtl/secded_pkg.sv
// Shared types and helpers for the SECDED scrubber: code geometry, scrub FSM
// states and the Hamming position map used by the encoder and decoder.
package secded_pkg;

    localparam int DATA_W = 64;
    localparam int CODE_W = 72;
    localparam int CHK_W  = 7;

    typedef enum logic [2:0] {
        IDLE,
        RD,
        DEC,
        EVAL,
        ENC,
        WR,
        NEXT
    } scrub_state_t;

    // Data bit k sits at the k-th non-power-of-two Hamming position (3, 5, 6, 7, 9, ...).
    function automatic logic [CHK_W-1:0] data_pos(input int k);
        logic [CHK_W-1:0] pos;
        int               n;
        pos = '0;
        n   = 0;
        for (int p = 3; p < CODE_W; p++) begin
            if ((p & (p - 1)) != 0) begin
                if (n == k) pos = CHK_W'(p);
                n++;
            end
        end
        return pos;
    endfunction

    function automatic logic [CHK_W-1:0] calc_chk(input logic [DATA_W-1:0] d);
        logic [CHK_W-1:0] c;
        logic [CHK_W-1:0] pos;
        c = '0;
        for (int k = 0; k < DATA_W; k++) begin
            pos = data_pos(k);
            for (int i = 0; i < CHK_W; i++) begin
                if (pos[i]) c[i] = c[i] ^ d[k];
            end
        end
        return c;
    endfunction

    function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
        logic [31:0] max;
        max = 32'hFFFF_FFFF >> (32 - width);
        return (val >= max) ? val : val + 32'd1;
    endfunction

endpackage

// File: rtl/secded_decoder.sv
// Registered SECDED decoder: corrects single errors, flags double errors.
module secded_decoder
    import secded_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [CODE_W-1:0] c_data,
    output logic [DATA_W-1:0] d_data,
    output logic              s_err,
    output logic              d_err,
    output logic              err
);

    logic [CHK_W-1:0]  syn;
    logic              par;
    logic [DATA_W-1:0] fix;
    logic              s_hit;
    logic              d_hit;

    // Odd parity with an in-range syndrome is correctable; syndrome 0 or a power
    // of two points at a check bit, so the data needs no flip.
    always_comb begin
        syn = calc_chk(c_data[DATA_W-1:0]) ^ c_data[DATA_W+CHK_W-1:DATA_W];
        par = ^c_data;
        fix = '0;
        for (int k = 0; k < DATA_W; k++) begin
            if (data_pos(k) == syn) fix[k] = 1'b1;
        end
        s_hit = par && (syn < CHK_W'(CODE_W));
        d_hit = (!par && (syn != '0)) || (par && (syn >= CHK_W'(CODE_W)));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            d_data <= '0;
            s_err  <= 1'b0;
            d_err  <= 1'b0;
            err    <= 1'b0;
        end else begin
            d_data <= c_data[DATA_W-1:0] ^ fix;
            s_err  <= s_hit;
            d_err  <= d_hit;
            err    <= s_hit | d_hit;
        end
    end

endmodule

// File: rtl/secded_encoder.sv
// Registered SECDED encoder: {overall parity, 7 Hamming checks, 64 data bits}.
module secded_encoder
    import secded_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic [DATA_W-1:0] d_data,
    output logic [CODE_W-1:0] e_data
);

    logic [CHK_W-1:0] chk;

    always_comb begin
        chk = calc_chk(d_data);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            e_data <= '0;
        end else begin
            e_data <= {^{chk, d_data}, chk, d_data};
        end
    end

endmodule

// File: rtl/secded_scrub_ctrl.sv
// Background memory scrubber: reads one word per interval, writes back corrected
// single errors and logs double errors. Host traffic always wins the port.
//
// state | meaning
// IDLE  | interval timer running, waiting for launch
// RD    | read request held until ack
// DEC   | decoder latency
// EVAL  | classify decoder result, bump counters
// ENC   | encoder latency, writeback abandoned if host is busy
// WR    | writeback request held until ack
// NEXT  | advance pointer, PASS_DONE on wrap
module secded_scrub_ctrl
    import secded_pkg::*;
#(
    parameter int ADDR_W   = 10,
    parameter int INTERVAL = 1024,
    parameter int CNT_W    = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              en,
    input  logic              clr,
    input  logic              host_busy,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CODE_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [CODE_W-1:0] mem_rdata,
    output logic [CNT_W-1:0]  se_cnt,
    output logic [CNT_W-1:0]  de_cnt,
    output logic              de_valid,
    output logic [ADDR_W-1:0] de_addr,
    output logic              pass_done,
    output logic              busy
);

    localparam int                TMR_W      = $clog2(INTERVAL);
    localparam logic [TMR_W-1:0]  TMR_RELOAD = TMR_W'(INTERVAL - 1);
    localparam logic [ADDR_W-1:0] PTR_LAST   = '1;

    scrub_state_t      state;
    scrub_state_t      state_nxt;
    logic [TMR_W-1:0]  tmr;
    logic [ADDR_W-1:0] ptr;
    logic [CODE_W-1:0] rdata_q;
    logic [CODE_W-1:0] wdata_q;
    logic [DATA_W-1:0] dec_data;
    logic              dec_s_err;
    logic              dec_d_err;
    logic              dec_err;
    logic [CODE_W-1:0] enc_data;
    logic              se_inc;
    logic              de_inc;

    secded_decoder u_dec (
        .clk    (clk),
        .rst_n  (rst_n),
        .c_data (rdata_q),
        .d_data (dec_data),
        .s_err  (dec_s_err),
        .d_err  (dec_d_err),
        .err    (dec_err)
    );

    secded_encoder u_enc (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_data (dec_data),
        .e_data (enc_data)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        mem_req   = 1'b0;
        mem_we    = 1'b0;
        pass_done = 1'b0;
        busy      = (state != IDLE);
        case (state)
            IDLE: begin
                if ((tmr == '0) && en && !host_busy) state_nxt = RD;
            end
            RD: begin
                mem_req = 1'b1;
                if (mem_ack) state_nxt = DEC;
            end
            DEC: begin
                state_nxt = EVAL;
            end
            EVAL: begin
                state_nxt = (dec_s_err && !dec_d_err) ? ENC : NEXT;
            end
            ENC: begin
                state_nxt = host_busy ? IDLE : WR;
            end
            WR: begin
                mem_req = 1'b1;
                mem_we  = 1'b1;
                if (mem_ack) state_nxt = NEXT;
            end
            NEXT: begin
                pass_done = (ptr == PTR_LAST);
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    assign mem_addr  = ptr;
    assign mem_wdata = wdata_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            tmr     <= TMR_RELOAD;
            ptr     <= '0;
            rdata_q <= '0;
            wdata_q <= '0;
        end else begin
            if (state == IDLE) begin
                if (state_nxt != IDLE) begin
                    tmr <= TMR_RELOAD;
                end else if (en && (tmr != '0)) begin
                    tmr <= tmr - 1'b1;
                end
            end
            if ((state == RD) && mem_ack) rdata_q <= mem_rdata;
            if ((state == ENC) && !host_busy) wdata_q <= enc_data;
            if (state == NEXT) ptr <= ptr + 1'b1;
        end
    end

    assign se_inc = (state == EVAL) && dec_s_err && !dec_d_err;
    assign de_inc = (state == EVAL) && dec_d_err;

    // A clear coinciding with a detection still records that detection.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            se_cnt   <= '0;
            de_cnt   <= '0;
            de_valid <= 1'b0;
            de_addr  <= '0;
        end else begin
            if (clr) begin
                se_cnt <= se_inc ? CNT_W'(1) : '0;
            end else if (se_inc) begin
                se_cnt <= CNT_W'(sat_inc(32'(se_cnt), CNT_W));
            end
            if (clr) begin
                de_cnt <= de_inc ? CNT_W'(1) : '0;
            end else if (de_inc) begin
                de_cnt <= CNT_W'(sat_inc(32'(de_cnt), CNT_W));
            end
            if (clr) begin
                de_valid <= de_inc;
                de_addr  <= de_inc ? ptr : '0;
            end else if (de_inc && !de_valid) begin
                de_valid <= 1'b1;
                de_addr  <= ptr;
            end
        end
    end

    a_err_consistent: assert property (@(posedge clk) disable iff (!rst_n)
        dec_err == (dec_s_err | dec_d_err));

endmodule

// File: tb/tb_secded_scrub_ctrl.sv
// Directed bench for secded_scrub_ctrl with a behavioural memory that acks
// after a programmable delay and keeps the stored (possibly corrupted) words.
module tb_secded_scrub_ctrl;

    localparam int ADDR_W   = 3;
    localparam int INTERVAL = 16;
    localparam int CNT_W    = 2;
    localparam int BUDGET   = 400;

    localparam logic [71:0] FLIP_S1 = 72'h00_0000_0000_0010_0000;
    localparam logic [71:0] FLIP_D  = 72'h00_0110_0000_0000_0000;
    localparam logic [71:0] FLIP_CB = 72'h04_0000_0000_0000_0000;
    localparam logic [71:0] W_CLEAN = 64'hDEAD_BEEF_CAFE_CAFE;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic              en = 1'b0;
    logic              clr = 1'b0;
    logic              host_busy = 1'b0;
    logic              mem_req;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [71:0]       mem_wdata;
    logic              mem_ack = 1'b0;
    logic [71:0]       mem_rdata = '0;
    logic [CNT_W-1:0]  se_cnt;
    logic [CNT_W-1:0]  de_cnt;
    logic              de_valid;
    logic [ADDR_W-1:0] de_addr;
    logic              pass_done;
    logic              busy;

    int n_vec = 0;
    int n_err = 0;

    logic [71:0] mem [8];
    int          ack_dly = 0;
    int          req_len = 0;
    logic        ack_q = 1'b0;
    int          rd_cnt = 0, wr_cnt = 0, pass_cnt = 0;
    int          stall_err = 0, hold_err = 0;
    int          last_rd_len = 0, last_wr_len = 0;
    logic [ADDR_W-1:0] last_wr_addr = '0;
    logic [71:0] last_wr_data = '0;
    logic [ADDR_W-1:0] req_addr;
    logic        req_we;
    logic [71:0] req_wdata;

    secded_scrub_ctrl #(
        .ADDR_W   (ADDR_W),
        .INTERVAL (INTERVAL),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .en        (en),
        .clr       (clr),
        .host_busy (host_busy),
        .mem_req   (mem_req),
        .mem_we    (mem_we),
        .mem_addr  (mem_addr),
        .mem_wdata (mem_wdata),
        .mem_ack   (mem_ack),
        .mem_rdata (mem_rdata),
        .se_cnt    (se_cnt),
        .de_cnt    (de_cnt),
        .de_valid  (de_valid),
        .de_addr   (de_addr),
        .pass_done (pass_done),
        .busy      (busy)
    );

    always #5 clk = ~clk;

    // Textbook Hamming layout: fill non-power-of-two positions 1..71 with data,
    // check bit i covers every position whose index has bit i set.
    function automatic logic [71:0] ref_enc(input logic [63:0] d);
        logic [71:0] h;
        logic [6:0]  c;
        int          k;
        h = '0;
        k = 0;
        for (int p = 1; p < 72; p++) begin
            if (p != 1 && p != 2 && p != 4 && p != 8 && p != 16 && p != 32 && p != 64) begin
                h[p] = d[k];
                k++;
            end
        end
        for (int i = 0; i < 7; i++) begin
            c[i] = 1'b0;
            for (int p = 1; p < 72; p++) begin
                if (p[i]) c[i] = c[i] ^ h[p];
            end
        end
        return {^{c, d}, c, d};
    endfunction

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic wait_pass(input int target);
        for (int i = 0; i < BUDGET && pass_cnt < target; i++) @(negedge clk);
        chk($sformatf("pass%0d_reached", target), 72'(pass_cnt >= target), 72'd1);
    endtask

    // Memory responder; also checks request stability and the post-ack drop.
    always @(negedge clk) begin
        if (ack_q && mem_req) hold_err++;
        ack_q   = mem_ack;
        mem_ack = 1'b0;
        if (mem_req) begin
            if (req_len == 0) begin
                req_addr  = mem_addr;
                req_we    = mem_we;
                req_wdata = mem_wdata;
            end else if (mem_addr != req_addr || mem_we != req_we ||
                         (mem_we && mem_wdata != req_wdata)) begin
                stall_err++;
            end
            if (req_len == ack_dly) begin
                mem_ack = 1'b1;
                if (mem_we) begin
                    mem[mem_addr] = mem_wdata;
                    wr_cnt++;
                    last_wr_addr = mem_addr;
                    last_wr_data = mem_wdata;
                    last_wr_len  = req_len + 1;
                end else begin
                    mem_rdata   = mem[mem_addr];
                    rd_cnt++;
                    last_rd_len = req_len + 1;
                end
                req_len = 0;
            end else begin
                req_len++;
            end
        end else begin
            req_len = 0;
        end
        if (pass_done) pass_cnt++;
    end

    initial begin
        logic [71:0] cw_x, cw_y;
        cw_x = ref_enc(64'h0123_4567_89AB_CDEF);
        cw_y = ref_enc(64'hFEDC_BA98_7654_3210);
        for (int a = 0; a < 8; a++) mem[a] = ref_enc(W_CLEAN[63:0]);

        // Reset state
        repeat (3) @(negedge clk);
        chk("rst_req_we_busy", {69'd0, mem_req, mem_we, busy}, 72'd0);
        chk("rst_addr_wdata", {mem_addr, mem_wdata} , 75'd0);
        chk("rst_counters", {68'd0, se_cnt, de_cnt}, 72'd0);
        chk("rst_de_log_pass", {67'd0, de_valid, de_addr, pass_done}, 72'd0);

        // Clean pass, with the first launch timed against the interval timer
        rst_n = 1'b1;
        en    = 1'b1;
        repeat (15) @(negedge clk);
        chk("timer_not_expired", 72'(mem_req), 72'd0);
        @(negedge clk);
        chk("first_launch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 3'd0});
        wait_pass(1);
        repeat (3) @(negedge clk);
        chk("clean_pass_pulses", 72'(pass_cnt), 72'd1);
        chk("clean_reads", 72'(rd_cnt), 72'd8);
        chk("clean_writes", 72'(wr_cnt), 72'd0);
        chk("clean_counters", {68'd0, se_cnt, de_cnt}, 72'd0);

        // Single error at addr 2, double errors at 5 and 6
        mem[2] = ref_enc(64'hCAFE_CAFE_DEAD_BEEF) ^ FLIP_S1;
        mem[5] = ref_enc(W_CLEAN[63:0]) ^ FLIP_D;
        mem[6] = ref_enc(W_CLEAN[63:0]) ^ FLIP_D;
        for (int i = 0; i < BUDGET && de_cnt != 2'd1; i++) @(negedge clk);
        chk("de_first_count", 72'(de_cnt), 72'd1);
        chk("de_first_log", {de_valid, de_addr}, {1'b1, 3'd5});
        chk("se_after_addr2", 72'(se_cnt), 72'd1);
        chk("wb_addr2", {last_wr_addr, last_wr_data}, {3'd2, ref_enc(64'hCAFE_CAFE_DEAD_BEEF)});
        wait_pass(2);
        chk("de_second_count", 72'(de_cnt), 72'd2);
        chk("de_addr_kept", {de_valid, de_addr}, {1'b1, 3'd5});
        chk("no_wb_for_double", 72'(wr_cnt), 72'd1);
        mem[5] = ref_enc(W_CLEAN[63:0]);
        mem[6] = ref_enc(W_CLEAN[63:0]);

        // Host busy across timer expiry delays the launch
        host_busy = 1'b1;
        repeat (30) @(negedge clk);
        chk("hb_hold_no_req", {mem_req, busy}, 2'b00);
        chk("hb_hold_reads", 72'(rd_cnt), 72'd16);
        host_busy = 1'b0;
        @(negedge clk);
        chk("hb_release_launch", {mem_req, mem_we, mem_addr}, {1'b1, 1'b0, 3'd0});
        wait_pass(3);
        chk("reread_addr2_clean", {se_cnt, 32'(wr_cnt)}, {2'd1, 32'd1});

        // CLR on the S_ERR cycle, then host busy in ENC abandons the writeback
        mem[3] = cw_x ^ FLIP_CB;
        for (int i = 0; i < BUDGET && !(mem_req && !mem_we && mem_addr == 3'd3); i++) @(negedge clk);
        chk("rd_addr3_seen", {mem_req, mem_addr}, {1'b1, 3'd3});
        @(negedge clk);
        @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr       = 1'b0;
        host_busy = 1'b1;
        chk("clr_with_serr", 72'(se_cnt), 72'd1);
        chk("clr_de_log", {de_cnt, de_valid, de_addr}, {2'd0, 1'b0, 3'd0});
        @(negedge clk);
        chk("enc_abandon_idle", {mem_req, busy}, 2'b00);
        repeat (2) @(negedge clk);
        host_busy = 1'b0;
        chk("enc_abandon_no_wr", 72'(wr_cnt), 72'd1);
        for (int i = 0; i < BUDGET && wr_cnt < 2; i++) @(negedge clk);
        chk("rescrub_wb", {last_wr_addr, last_wr_data}, {3'd3, cw_x});
        chk("rescrub_se", 72'(se_cnt), 72'd2);

        // Stalled handshake in both read and write
        wait_pass(4);
        ack_dly = 5;
        mem[5]  = cw_y ^ (72'h1 << 33);
        wait_pass(5);
        chk("stall_wb", {last_wr_addr, last_wr_data}, {3'd5, cw_y});
        chk("stall_lengths", {32'(last_rd_len), 32'(last_wr_len)}, {32'd6, 32'd6});
        chk("stall_stable", 72'(stall_err), 72'd0);
        chk("req_drop_after_ack", 72'(hold_err), 72'd0);
        chk("se_saturates_3", 72'(se_cnt), 72'd3);

        // Saturation after CLR: five single errors in one pass
        ack_dly = 0;
        clr     = 1'b1;
        mem[0]  = ref_enc(W_CLEAN[63:0]) ^ 72'h1;
        mem[1]  = ref_enc(W_CLEAN[63:0]) ^ (72'h1 << 63);
        mem[2]  = ref_enc(W_CLEAN[63:0]) ^ (72'h1 << 71);
        mem[4]  = ref_enc(W_CLEAN[63:0]) ^ (72'h1 << 64);
        mem[6]  = ref_enc(W_CLEAN[63:0]) ^ (72'h1 << 30);
        @(negedge clk);
        clr = 1'b0;
        chk("clr_idle", {se_cnt, de_cnt}, 4'd0);
        wait_pass(6);
        chk("sat_se", 72'(se_cnt), 72'd3);
        chk("sat_writes", 72'(wr_cnt), 72'd8);
        chk("sat_mem6_fixed", mem[6], ref_enc(W_CLEAN[63:0]));

        // Reset in the middle of a stalled writeback
        ack_dly = 5;
        mem[1]  = cw_x ^ (72'h1 << 10);
        for (int i = 0; i < BUDGET && !(mem_req && mem_we); i++) @(negedge clk);
        chk("wr_addr1_seen", {mem_req, mem_we, mem_addr}, {1'b1, 1'b1, 3'd1});
        rst_n = 1'b0;
        @(negedge clk);
        chk("rst_wr_req", {mem_req, mem_we, busy, pass_done}, 4'd0);
        chk("rst_wr_data", {mem_addr, mem_wdata}, 75'd0);
        chk("rst_wr_counts", {se_cnt, de_cnt, de_valid, de_addr}, 8'd0);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_idle", {mem_req, busy}, 2'b00);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/secded_scrub_ctrl.md
Name: secded_scrub_ctrl

Overview:
Background scrubber for a SECDED-protected 72-bit-wide memory (64 data bits plus 8 check bits). It periodically reads one word and decodes it. A correctable (single) error is re-encoded and written back; an uncorrectable (double) error is logged. Host traffic always has priority, and the scrubber shares the memory port only while HOST_BUSY is low.

Parameters:
ADDR_W, 10, memory address width; the scrub pointer wraps at 2^ADDR_W-1.
INTERVAL, 1024, cycles between scrub launches (must be >= 2).
CNT_W, 16, width of the saturating error counters.

Ports:
CLK  in  1  clock, rising edge.
RST_N  in  1  synchronous active-low reset.
EN  in  1  scrub enable.
CLR  in  1  clears error counters and the double-error log.
HOST_BUSY  in  1  host owns the memory port; no new scrub request may start.
MEM_REQ  out  1  memory request.
MEM_WE  out  1  1 = write, 0 = read; valid with MEM_REQ.
MEM_ADDR  out  ADDR_W  request address.
MEM_WDATA  out  72  codeword to write.
MEM_ACK  in  1  request accepted; read data valid in the same cycle.
MEM_RDATA  in  72  raw codeword.
SE_CNT  out  CNT_W  corrected single-error count, saturating.
DE_CNT  out  CNT_W  double-error count, saturating.
DE_VALID  out  1  sticky flag: a double error has been logged.
DE_ADDR  out  ADDR_W  address of the first double error since reset or CLR.
PASS_DONE  out  1  one-cycle pulse when the pointer wraps to 0.
BUSY  out  1  high in every state except IDLE.

Behaviour:
- Reset (RST_N=0 at edge): state IDLE, pointer 0, timer = INTERVAL-1. MEM_REQ, MEM_WE, MEM_ADDR, MEM_WDATA, SE_CNT, DE_CNT, DE_VALID, DE_ADDR, PASS_DONE and BUSY are all 0. Reset mid-transaction drops MEM_REQ on the next edge; no completion is required.
- Timer: decrements in IDLE only while EN=1, holds at 0, and reloads to INTERVAL-1 on leaving IDLE.
- IDLE -> RD: when timer==0, EN=1 and HOST_BUSY=0. EN=0 or HOST_BUSY=1 at timer 0 waits in IDLE.
- RD: MEM_REQ=1, MEM_WE=0, MEM_ADDR=pointer. Hold until MEM_ACK=1, capture MEM_RDATA, go to DEC. HOST_BUSY is ignored once a request is raised; a request is never withdrawn.
- DEC: one cycle for the registered secded_decoder (1-cycle latency), then go to EVAL.
- EVAL, classified on the decoder outputs:
  - No error -> NEXT.
  - D_ERR: increment DE_CNT. If DE_VALID=0, set DE_VALID=1 and DE_ADDR=pointer. No writeback. -> NEXT.
  - S_ERR: increment SE_CNT, present D_DATA to the registered secded_encoder. -> ENC.
- ENC: one cycle for encoder latency. Then:
  - If HOST_BUSY=0, go to WR with MEM_WDATA = E_DATA.
  - If HOST_BUSY=1, abandon the writeback and go to IDLE without advancing the pointer, so the same address is re-scrubbed next interval.
- Re-scrub double counting: a re-scrubbed address that still has a single error increments SE_CNT again. This is intended; SE_CNT counts detections.
- WR: MEM_REQ=1, MEM_WE=1, same address, MEM_WDATA stable until MEM_ACK=1. Then go to NEXT.
- MEM_REQ deasserts on the edge after the ack cycle. Back-to-back requests always have at least one idle cycle between them.
- NEXT: pointer+1, wrapping from 2^ADDR_W-1 to 0. PASS_DONE=1 for this one cycle only on the wrap. -> IDLE.
- Counters saturate at all ones.
- CLR takes effect on the next edge: counters go to 0, DE_VALID and DE_ADDR to 0. If CLR coincides with an increment, the counter becomes 1 (and DE_VALID/DE_ADDR capture if a D_ERR coincides). CLR does not affect the FSM or the pointer.
- ERR is used only for assertions: it must equal S_ERR|D_ERR.

Decomposition:
- secded_pkg holds: DATA_W=64, CODE_W=72; state enum scrub_state_t {IDLE, RD, DEC, EVAL, ENC, WR, NEXT}; helper function sat_inc.
- Reuse the existing secded_encoder and secded_decoder instances.
- No new sub-module; the timer and FSM live inline.

Test Plan:
- Clean memory. With INTERVAL=16 and ADDR_W=3, load all 8 words with encode(64'hDEAD_BEEF_CAFE_CAFE). After 8 launches, PASS_DONE pulses exactly once, SE_CNT=0, DE_CNT=0, and no write request occurs.
- Single error. Addr 2 returns the codeword ^ 72'h00_0000_0000_0010_0000. Expect SE_CNT=1 and a write to addr 2 with encode(64'hCAFE_CAFE_DEAD_BEEF). The re-read on the next pass is clean.
- Double error. Addr 5 returns the codeword ^ 72'h00_0110_0000_0000_0000. Expect DE_CNT=1, DE_VALID=1, DE_ADDR=5, no write. A second double error at addr 6 leaves DE_ADDR=5 and makes DE_CNT=2.
- Host contention:
  - HOST_BUSY=1 at timer 0 delays MEM_REQ until it drops.
  - HOST_BUSY=1 during ENC on a single error gives no write and the pointer is unchanged. The next interval re-reads the same address and SE_CNT=2 after the write completes.
- Handshake stall. MEM_ACK delayed 5 cycles in both RD and WR: MEM_REQ, MEM_ADDR and MEM_WDATA stay stable throughout, and MEM_REQ falls the edge after the ack.
- Reset/CLR/saturation:
  - RST_N low during WR drops MEM_REQ next edge with all outputs 0.
  - CLR coinciding with an S_ERR gives SE_CNT=1.
  - With CNT_W=2, five single errors leave SE_CNT=3.
